hilo_muldiv_unit: RTL

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/hilo_muldiv_unit_pkg.sv | 34 +++
 rtl/hilo_muldiv_unit_iter_core.sv | 81 ++++++++
 rtl/hilo_muldiv_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide unit and the decode stage.
package hilo_muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MSUB  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Operations whose operands are treated as two's complement.
  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Operations that run the restoring divider.
  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide on unsigned
// magnitudes, one bit per cycle, with its own iteration counter.
module muldiv_iter_core #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(ITER + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   trial_s;

  // One multiply or divide iteration per step; load seeds the accumulator.
  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    sum_s   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};
    shl_s   = {hi_q, lo_q[WIDTH-1]};
    trial_s = shl_s - {1'b0, b_q};
    if (load_i) begin
      cnt_d = CW'(ITER);
      hi_d  = {WIDTH{1'b0}};
      lo_d  = a_i;
      b_d   = b_i;
    end else if (step_i && (cnt_q != {CW{1'b0}})) begin
      cnt_d = cnt_q - CW'(1);
      if (is_div_i) begin
        // Restoring step: keep the trial remainder only if it did not go negative.
        if (!trial_s[WIDTH]) begin
          hi_d = trial_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shl_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {sum_s, lo_q[WIDTH-1:1]};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign last_o = step_i && (cnt_q == CW'(1));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  // Iteration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CW{1'b0}};
      hi_q  <= {WIDTH{1'b0}};
      lo_q  <= {WIDTH{1'b0}};
      b_q   <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Hi/Lo multiply/divide unit: control FSM, operand latching with sign
// stripping, final sign fix-up/accumulate and the architectural Hi/Lo pair.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             divzero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  op_e              op_q, op_d, op_in_s;
  logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic             accept_s, a_neg_s, b_neg_s;
  logic             core_load_s, core_step_s, core_last_s;
  logic [WIDTH-1:0] core_hi_s, core_lo_s;
  logic [2*WIDTH-1:0] prod_s, sprod_s, result_s;

  assign op_in_s  = op_e'(op_i);
  // A request in the cycle Done is high is dropped on purpose.
  assign accept_s = (state_q == ST_IDLE) && start_i && !done_q;
  assign a_neg_s  = is_signed_op(op_in_s) && a_i[WIDTH-1];
  assign b_neg_s  = is_signed_op(op_in_s) && b_i[WIDTH-1];

  muldiv_iter_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (core_load_s),
    .step_i   (core_step_s),
    .is_div_i (is_div_op(op_q)),
    .a_i      (mag_a_q),
    .b_i      (mag_b_q),
    .last_o   (core_last_s),
    .hi_o     (core_hi_s),
    .lo_o     (core_lo_s)
  );

  // Re-apply operand signs to the magnitude result and accumulate for MADD/MSUB.
  always_comb begin
    prod_s  = {core_hi_s, core_lo_s};
    sprod_s = (neg_a_q ^ neg_b_q) ? (~prod_s + ONE_2W) : prod_s;
    case (op_q)
      OP_MULT:  result_s = sprod_s;
      OP_MULTU: result_s = prod_s;
      OP_DIV:   result_s = {(neg_a_q ? (~core_hi_s + ONE_W) : core_hi_s),
                            ((neg_a_q ^ neg_b_q) ? (~core_lo_s + ONE_W) : core_lo_s)};
      OP_DIVU:  result_s = prod_s;
      OP_MADD:  result_s = {hi_q, lo_q} + sprod_s;
      OP_MSUB:  result_s = {hi_q, lo_q} - sprod_s;
      default:  result_s = {hi_q, lo_q};
    endcase
  end

  // Next-state and register-update logic for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    first_d     = first_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dz_d        = 1'b0;
    core_load_s = 1'b0;
    core_step_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_in_s)
            OP_MTHI: begin
              hi_d   = a_i;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a_i;
              done_d = 1'b1;
            end
            default: begin
              if (is_div_op(op_in_s) && (b_i == {WIDTH{1'b0}})) begin
                done_d = 1'b1;
                dz_d   = 1'b1;
              end else begin
                state_d = ST_CALC;
                op_d    = op_in_s;
                neg_a_d = a_neg_s;
                neg_b_d = b_neg_s;
                mag_a_d = a_neg_s ? (~a_i + ONE_W) : a_i;
                mag_b_d = b_neg_s ? (~b_i + ONE_W) : b_i;
                first_d = 1'b1;
              end
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        // First CALC cycle seeds the core from the latched magnitudes.
        if (first_q) begin
          core_load_s = 1'b1;
          first_d     = 1'b0;
        end else begin
          core_step_s = 1'b1;
          if (core_last_s) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_FIX: begin
        state_d      = ST_IDLE;
        done_d       = 1'b1;
        {hi_d, lo_d} = result_s;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control, operand and Hi/Lo registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      mag_a_q <= {WIDTH{1'b0}};
      mag_b_q <= {WIDTH{1'b0}};
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      first_q <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      first_q <= first_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign divzero_o = dz_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule
